// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch unit: FSM encoding and parameter defaults.
package fetch_pkg;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRun   = 2'd1;
   localparam logic [1:0] StFlush = 2'd2;

   localparam int unsigned DefAddrW   = 32;
   localparam int unsigned DefInstW   = 32;
   localparam int unsigned DefDepth   = 4;
   localparam int unsigned DefPcStep  = 4;
   localparam logic [31:0] DefResetPc = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO with registered storage, flush and occupancy count.
module fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned    PtrW = $clog2(DEPTH);
   localparam logic [PtrW:0]  Full = (PtrW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign do_pop  = pop && (count_q != '0) && !flush;
   // A full buffer still takes a push when the head leaves in the same cycle.
   assign do_push = push && !flush && ((count_q != Full) || do_pop);

   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else if (do_push && !do_pop) begin
         count_d = count_q + (PtrW + 1)'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - (PtrW + 1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited sequential prefetch with redirect flush and
// in-order response tracking.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = DefAddrW,
   parameter int unsigned       INST_W   = DefInstW,
   parameter int unsigned       DEPTH    = DefDepth,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefResetPc),
   parameter int unsigned       PC_STEP  = DefPcStep
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc
);

   localparam int unsigned       CntW    = $clog2(DEPTH) + 1;
   localparam logic [ADDR_W-1:0] Step    = ADDR_W'(PC_STEP);
   localparam logic [CntW:0]     Credits = (CntW + 1)'(DEPTH);

   logic [1:0]               state_q, state_d;
   logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]        resp_pc_q, resp_pc_d;
   logic [CntW-1:0]          outst_q, outst_d;
   logic [CntW-1:0]          discard_q, discard_d;
   logic [CntW-1:0]          fifo_count;
   logic [INST_W+ADDR_W-1:0] fifo_rdata;
   logic [CntW:0]            in_use;
   logic [CntW-1:0]          pending;
   logic                     acked, rvalid_seen, push, pop;

   assign in_use      = (CntW + 1)'(fifo_count) + (CntW + 1)'(outst_q);
   assign imem_req    = (state_q == StRun) && en && (in_use < Credits);
   assign imem_addr   = fetch_pc_q;
   assign acked       = imem_req && imem_ack;
   assign rvalid_seen = imem_rvalid && (state_q != StIdle);
   // Responses the memory still owes after this cycle, kept or not.
   assign pending     = outst_q + discard_q + CntW'(acked) - CntW'(rvalid_seen);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      outst_d    = outst_q;
      discard_d  = discard_q;
      push       = 1'b0;
      if (redirect_valid) begin
         fetch_pc_d = redirect_target;
         resp_pc_d  = redirect_target;
         outst_d    = '0;
         discard_d  = pending;
         state_d    = (pending == '0) ? StRun : StFlush;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (en) state_d = StRun;
            end
            StRun: begin
               if (acked) fetch_pc_d = fetch_pc_q + Step;
               if (imem_rvalid) begin
                  push      = 1'b1;
                  resp_pc_d = resp_pc_q + Step;
               end
               outst_d = pending;
               if (!en && (outst_q == '0)) state_d = StIdle;
            end
            StFlush: begin
               discard_d = pending;
               if (pending == '0) state_d = en ? StRun : StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         outst_q    <= '0;
         discard_q  <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
      end
   end

   assign pop = inst_valid && inst_ready && !redirect_valid;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (INST_W + ADDR_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_valid),
      .push  (push),
      .wdata ({imem_rdata, resp_pc_q}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .count (fifo_count)
   );

   assign inst_valid = (fifo_count != '0);
   assign inst_data  = fifo_rdata[ADDR_W +: INST_W];
   assign inst_pc    = fifo_rdata[ADDR_W-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a cycle table for the prefetch/credit behaviour plus
// hand sequences for redirect, wrap-around and reset corner cases.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        en = 1'b0;
   logic        imem_ack = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        inst_ready = 1'b0;
   logic        imem_req, inst_valid;
   logic [31:0] imem_addr, inst_data, inst_pc;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   logic        tbl_mode = 1'b1;
   logic        t_rvalid = 1'b0;
   logic [31:0] t_rdata = '0;
   logic        resp_en = 1'b0;
   logic        m_rvalid = 1'b0;
   logic [31:0] m_rdata = '0;
   logic [31:0] addr_q[$];

   int unsigned n_vec = 0;
   int unsigned n_fail = 0;
   int          drops, leak, got_req, seen, bad;
   logic [31:0] first_pc, first_data;
   logic [31:0] pcs[2];

   assign imem_rvalid = tbl_mode ? t_rvalid : m_rvalid;
   assign imem_rdata  = tbl_mode ? t_rdata  : m_rdata;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk             (clk),
      .rst             (rst),
      .en              (en),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst_data       (inst_data),
      .inst_pc         (inst_pc)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // In-order memory: one-cycle response latency, reset together with the DUT.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q.delete();
         m_rvalid <= 1'b0;
         m_rdata  <= '0;
      end else begin
         if (imem_req && imem_ack) addr_q.push_back(imem_addr);
         if (resp_en && addr_q.size() != 0) begin
            m_rvalid <= 1'b1;
            m_rdata  <= mem_word(addr_q.pop_front());
         end else begin
            m_rvalid <= 1'b0;
         end
      end
   end

   typedef struct {
      logic        en, ack, rv, rdy;
      logic [31:0] rdata;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc, data;
   } vec_t;

   vec_t tbl[14];

   function automatic vec_t mk(input logic e, input logic a, input logic rv,
                               input logic [31:0] rd, input logic rdy, input logic req,
                               input logic [31:0] addr, input logic v, input logic [31:0] pc,
                               input logic [31:0] data);
      vec_t t;
      t.en = e; t.ack = a; t.rv = rv; t.rdata = rd; t.rdy = rdy;
      t.req = req; t.addr = addr; t.valid = v; t.pc = pc; t.data = data;
      return t;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b0; en = 1'b0; imem_ack = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      inst_ready = 1'b0; resp_en = 1'b0; t_rvalid = 1'b0; t_rdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      //        en ack rv rdata  rdy | req addr   valid pc  data
      tbl[0]  = mk(1, 1, 0, 32'h0,  0,   0, 32'h00, 0, 32'h0, 32'h0);
      tbl[1]  = mk(1, 1, 0, 32'h0,  0,   1, 32'h00, 0, 32'h0, 32'h0);
      tbl[2]  = mk(1, 1, 0, 32'h0,  0,   1, 32'h04, 0, 32'h0, 32'h0);
      tbl[3]  = mk(1, 1, 0, 32'h0,  0,   1, 32'h08, 0, 32'h0, 32'h0);
      tbl[4]  = mk(1, 1, 0, 32'h0,  0,   1, 32'h0C, 0, 32'h0, 32'h0);
      tbl[5]  = mk(1, 1, 1, 32'hA0, 0,   0, 32'h10, 0, 32'h0, 32'h0);
      tbl[6]  = mk(1, 1, 1, 32'hA1, 0,   0, 32'h10, 1, 32'h0, 32'hA0);
      tbl[7]  = mk(1, 1, 1, 32'hA2, 0,   0, 32'h10, 1, 32'h0, 32'hA0);
      tbl[8]  = mk(1, 1, 1, 32'hA3, 0,   0, 32'h10, 1, 32'h0, 32'hA0);
      tbl[9]  = mk(1, 1, 0, 32'h0,  0,   0, 32'h10, 1, 32'h0, 32'hA0);
      tbl[10] = mk(1, 0, 0, 32'h0,  1,   0, 32'h10, 1, 32'h0, 32'hA0);
      tbl[11] = mk(1, 0, 0, 32'h0,  1,   1, 32'h10, 1, 32'h4, 32'hA1);
      tbl[12] = mk(1, 1, 0, 32'h0,  0,   1, 32'h10, 1, 32'h8, 32'hA2);
      tbl[13] = mk(1, 0, 0, 32'h0,  0,   1, 32'h14, 1, 32'h8, 32'hA2);

      rst = 1'b1;
      #1 rst = 1'b0;
      #1 check("reset_outputs", {imem_req, imem_addr, inst_valid, inst_data, inst_pc},
               {1'b0, 32'h0, 1'b0, 32'h0, 32'h0});

      // Prefetch until credits run out, fill the buffer, then drain and resume.
      apply_reset();
      tbl_mode = 1'b1;
      for (int i = 0; i < 14; i++) begin
         en = tbl[i].en; imem_ack = tbl[i].ack; t_rvalid = tbl[i].rv;
         t_rdata = tbl[i].rdata; inst_ready = tbl[i].rdy;
         #1 check($sformatf("vec%0d", i),
                  {imem_req, imem_addr, inst_valid, inst_pc, inst_data},
                  {tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].pc, tbl[i].data});
         @(posedge clk);
         #1;
      end

      // Redirect with three requests in flight: all three responses dropped.
      apply_reset();
      tbl_mode = 1'b0; en = 1'b1; imem_ack = 1'b1;
      cyc(); cyc(); cyc(); cyc();
      imem_ack = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h100;
      cyc();
      redirect_valid = 1'b0;
      #1 check("flush_req_low", imem_req, 0);
      check("flush_valid_low", inst_valid, 0);
      resp_en = 1'b1; imem_ack = 1'b1;
      drops = 0; leak = 0; got_req = 0;
      for (int i = 0; i < 12 && got_req == 0; i++) begin
         cyc();
         if (imem_rvalid) drops++;
         if (inst_valid) leak++;
         if (imem_req) got_req = 1;
      end
      check("flush_drops", drops, 3);
      check("flush_leak", leak, 0);
      check("flush_resume", got_req, 1);
      check("flush_addr", imem_addr, 32'h100);
      inst_ready = 1'b1; seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
         cyc();
         if (inst_valid) begin seen = 1; first_pc = inst_pc; first_data = inst_data; end
      end
      check("flush_first_seen", seen, 1);
      check("flush_first_pc", first_pc, 32'h100);
      check("flush_first_data", first_data, mem_word(32'h100));

      // Back-to-back redirects: nothing from the first target may reach decode.
      apply_reset();
      tbl_mode = 1'b0; en = 1'b1; imem_ack = 1'b1; resp_en = 1'b1; inst_ready = 1'b1;
      repeat (4) cyc();
      redirect_valid = 1'b1; redirect_target = 32'h100;
      cyc();
      redirect_valid = 1'b0;
      #1 check("redir1_valid_low", inst_valid, 0);
      cyc();
      redirect_valid = 1'b1; redirect_target = 32'h200;
      cyc();
      redirect_valid = 1'b0;
      #1 check("redir2_valid_low", inst_valid, 0);
      seen = 0; bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (inst_valid) begin
            if (inst_pc < 32'h200) bad++;
            if (seen == 0) begin seen = 1; first_pc = inst_pc; first_data = inst_data; end
         end
         cyc();
      end
      check("redir2_seen", seen, 1);
      check("redir2_first_pc", first_pc, 32'h200);
      check("redir2_first_data", first_data, mem_word(32'h200));
      check("redir2_stale", bad, 0);

      // Fetch address wraps from the top of the address space.
      apply_reset();
      tbl_mode = 1'b0; en = 1'b1; imem_ack = 1'b1; resp_en = 1'b1; inst_ready = 1'b1;
      cyc();
      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
      cyc();
      redirect_valid = 1'b0;
      got_req = 0;
      for (int i = 0; i < 10 && got_req == 0; i++) begin
         #1 if (imem_req) got_req = 1; else cyc();
      end
      check("wrap_req", got_req, 1);
      check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      cyc();
      check("wrap_addr1", {imem_req, imem_addr}, {1'b1, 32'h0});
      seen = 0;
      for (int i = 0; i < 12 && seen < 2; i++) begin
         if (inst_valid) begin pcs[seen] = inst_pc; seen++; end
         cyc();
      end
      check("wrap_deliver_cnt", seen, 2);
      check("wrap_deliver_pcs", {pcs[0], pcs[1]}, {32'hFFFF_FFFC, 32'h0});

      // Reset in the middle of a flush with two responses still owed.
      apply_reset();
      tbl_mode = 1'b0; en = 1'b1; imem_ack = 1'b1;
      cyc(); cyc(); cyc();
      imem_ack = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h300;
      cyc();
      redirect_valid = 1'b0;
      #1 check("rstflush_in_flush", {imem_req, imem_addr}, {1'b0, 32'h300});
      #2 rst = 1'b0;
      #1 check("rstflush_outputs", {imem_req, imem_addr, inst_valid, inst_data, inst_pc},
               {1'b0, 32'h0, 1'b0, 32'h0, 32'h0});
      @(posedge clk);
      #1 rst = 1'b1; imem_ack = 1'b1; resp_en = 1'b1; inst_ready = 1'b1;
      cyc();
      check("rstflush_first_req", {imem_req, imem_addr}, {1'b1, 32'h0});
      seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
         cyc();
         if (inst_valid) begin seen = 1; first_pc = inst_pc; first_data = inst_data; end
      end
      check("rstflush_deliver", {seen[0], first_pc, first_data}, {1'b1, 32'h0, mem_word(32'h0)});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC and memory address width.
REQ-002 SHALL have parameter INST_W, default 32, instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, prefetch buffer entries; power of two, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-005 SHALL have parameter PC_STEP, default 4, sequential address increment.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port en, input, 1, fetch enable; when low no new requests issue.
REQ-009 SHALL have port imem_req, output, 1, request valid to instruction memory.
REQ-010 SHALL have port imem_addr, output, ADDR_W, request address.
REQ-011 SHALL have port imem_ack, input, 1, request accepted this cycle.
REQ-012 SHALL have port imem_rvalid, input, 1, response valid; responses return in request order.
REQ-013 SHALL have port imem_rdata, input, INST_W, response instruction.
REQ-014 SHALL have port redirect_valid, input, 1, one-cycle jump/branch redirect.
REQ-015 SHALL have port redirect_target, input, ADDR_W, absolute redirect address.
REQ-016 SHALL have port inst_valid, output, 1, buffered instruction available.
REQ-017 SHALL have port inst_ready, input, 1, decode stage accepts.
REQ-018 SHALL have port inst_data, output, INST_W, head instruction.
REQ-019 SHALL have port inst_pc, output, ADDR_W, address of head instruction.

Function
REQ-020 SHALL run FSM states IDLE, RUN, FLUSH; reset state IDLE.
REQ-021 SHALL move IDLE->RUN when en is high; RUN->IDLE when en is low and no request is outstanding.
REQ-022 SHALL in RUN assert imem_req, with imem_addr = fetch_pc, only while en is high and (buffer count + outstanding) < DEPTH.
REQ-023 SHALL hold imem_req and imem_addr stable until imem_ack; on imem_ack, fetch_pc += PC_STEP (mod 2^ADDR_W) and outstanding increments.
REQ-024 SHALL on imem_rvalid in RUN push {imem_rdata, its request address} into the buffer and decrement outstanding; same-cycle ack and rvalid leave outstanding unchanged.
REQ-025 SHALL present the buffer head on inst_data/inst_pc with inst_valid = not empty, and pop on inst_valid and inst_ready.
REQ-026 SHALL accept a push and a pop in the same cycle when full; the credit rule of REQ-022 guarantees no overflow.
REQ-027 SHALL on redirect_valid (any state) empty the buffer, deassert imem_req the next cycle, set fetch_pc = redirect_target, load discard count = outstanding (including a same-cycle ack), and enter FLUSH.
REQ-028 SHALL in FLUSH drop every imem_rvalid and decrement the discard count; FLUSH->RUN (or IDLE if en is low) when the count reaches zero.
REQ-029 SHALL bypass FLUSH and go directly to RUN when the discard count is zero at redirect.
REQ-030 SHALL give a later redirect priority over any pending one: retarget to the latest and keep counting discards.
REQ-031 SHALL have a latency from imem_rvalid to inst_valid of one cycle (registered buffer); inst_valid never depends combinationally on imem_rvalid.
REQ-032 SHALL not pop during redirect; inst_valid is low the cycle after redirect_valid.

Reset
REQ-033 SHALL asynchronously, on rst low, set state IDLE, fetch_pc = RESET_PC, buffer empty, outstanding and discard count 0.
REQ-034 SHALL drive imem_req 0, imem_addr RESET_PC, inst_valid 0, inst_data 0, inst_pc 0 during reset.
REQ-035 SHALL drop responses arriving after reset release for requests issued before reset; the memory side is reset together with this block.

Structure
REQ-036 SHALL place FSM state encoding and the default parameter constants in a shared package, fetch_pkg.
REQ-037 SHALL implement the buffer as one sub-module, fetch_fifo (DEPTH x (INST_W+ADDR_W), registered head, count output).

Verification
REQ-038 Reset release with en=1 and imem_ack tied high -> requests at 0x0, 0x4, 0x8, 0xC; imem_req drops with 4 in flight; responses appear in order with matching inst_pc.
REQ-039 inst_ready=0, memory answering every request -> exactly DEPTH=4 entries, then imem_req stays low; inst_ready=1 resumes at 0x10.
REQ-040 redirect_valid to 0x100 with 3 outstanding -> FLUSH; 3 rvalids dropped, inst_valid low; next request address is 0x100.
REQ-041 Two redirects 2 cycles apart (0x100, then 0x200) -> no instruction from 0x100 delivered; first delivered inst_pc is 0x200.
REQ-042 fetch_pc 0xFFFFFFFC -> next request address 0x00000000.
REQ-043 rst low mid-FLUSH with 2 outstanding -> all outputs return to reset values immediately; after release, the first request is at RESET_PC.
